// File: rtl/sram_cmd_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | sram_cmd_sequencer_pkg : command codes and frame type for the SRAM    |
// | command sequencer.                                Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

package sram_cmd_sequencer_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'd1;
  localparam logic [7:0] CMD_LOAD     = 8'd2;
  localparam logic [7:0] CMD_WRITE    = 8'd3;
  localparam logic [7:0] CMD_READ     = 8'd4;
  localparam logic [7:0] CMD_READ_REQ = 8'd5;
  localparam logic [7:0] CMD_COUNT    = 8'd6;
  localparam logic [7:0] CMD_CONST    = 8'd7;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] arg;
  } frame_t;

endpackage

`default_nettype wire

// File: rtl/sram_cmd_sequencer_frame_rx.sv
// +----------------------------------------------------------------------+
// | cmd_frame_rx : assembles 6-byte command frames, checks the terminator |
// | and drops stalled partial frames.                 Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module cmd_frame_rx #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strb,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [39:0]   bytes_q, bytes_d;

  // frame_valid/frame_err are combinational so the sequencer reaches DECODE
  // on the same edge that samples the terminator byte.
  always_comb begin
    idx_d       = idx_q;
    idle_d      = idle_q;
    bytes_d     = bytes_q;
    frame_valid = 1'b0;
    frame_err   = 1'b0;
    if (rx_strb) begin
      idle_d = '0;
      if (idx_q == 3'd5) begin
        idx_d       = 3'd0;
        frame_valid = (rx_data == 8'h00);
        frame_err   = (rx_data != 8'h00);
      end else begin
        idx_d   = idx_q + 3'd1;
        bytes_d = {bytes_q[31:0], rx_data};
      end
    end else if (idx_q != 3'd0) begin
      if (idle_q == TW'(TIMEOUT_CYC)) begin
        idx_d  = 3'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 3'd0;
      idle_q  <= '0;
      bytes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      bytes_q <= bytes_d;
    end
  end

  assign cmd = bytes_q[39:32];
  assign arg = bytes_q[31:0];

endmodule

`default_nettype wire

// File: rtl/sram_cmd_sequencer.sv
// +----------------------------------------------------------------------+
// | sram_cmd_sequencer : decodes UART command frames and sequences SRAM   |
// | write, read, fill and read-back cycles.           Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_cmd_sequencer
  import sram_cmd_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_strb,
  output logic [7:0]        tx_data,
  output logic              tx_strb,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_data_write,
  output logic              sram_data_oe,
  input  logic [7:0]        sram_data_read,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_WR_SETUP  = 4'd2;
  localparam logic [3:0] S_WR_PULSE  = 4'd3;
  localparam logic [3:0] S_WR_HOLD   = 4'd4;
  localparam logic [3:0] S_RD_SETUP  = 4'd5;
  localparam logic [3:0] S_RD_PULSE  = 4'd6;
  localparam logic [3:0] S_TX_RDY    = 4'd7;
  localparam logic [3:0] S_TX_ACK    = 4'd8;
  localparam logic [3:0] S_FILL_NEXT = 4'd9;

  localparam int CW = 16;

  logic        frame_valid, frame_err;
  logic [7:0]  f_cmd;
  logic [31:0] f_arg;

  cmd_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_strb     (rx_strb),
    .frame_valid (frame_valid),
    .cmd         (f_cmd),
    .arg         (f_arg),
    .frame_err   (frame_err)
  );

  logic [3:0]        state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [31:0]       fill_q, fill_d;
  logic [31:0]       num_q, num_d;
  logic              count_q, count_d;
  frame_t            frame_q, frame_d;
  logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic              data_oe_q, data_oe_d, tx_strb_q, tx_strb_d;
  logic              busy_q, busy_d, err_q, err_d;
  logic              wr_phase, rd_phase;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    fill_d     = fill_q;
    num_d      = num_q;
    count_d    = count_q;
    frame_d    = frame_q;
    addr_reg_d = addr_reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;
    err_d      = frame_err | (frame_valid & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          frame_d = '{cmd: f_cmd, arg: f_arg};
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        fill_d  = '0;
        case (frame_q.cmd)
          CMD_ADDR: addr_reg_d = frame_q.arg[ADDR_W-1:0];
          CMD_LOAD: wdata_d = frame_q.arg[7:0];
          CMD_WRITE: begin
            count_d = 1'b0;
            num_d   = 32'd1;
            state_d = S_WR_SETUP;
          end
          CMD_READ_REQ: state_d = S_RD_SETUP;
          CMD_READ: begin
            tx_data_d = rdata_q;
            state_d   = S_TX_RDY;
          end
          CMD_COUNT, CMD_CONST: begin
            count_d = (frame_q.cmd == CMD_COUNT);
            num_d   = frame_q.arg;
            if (frame_q.arg != 32'd0) state_d = S_WR_SETUP;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_WR_SETUP: begin
        if (cyc_q == CW'(SETUP_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_WR_PULSE;
        end else cyc_d = cyc_q + CW'(1);
      end
      S_WR_PULSE: begin
        if (cyc_q == CW'(PULSE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_WR_HOLD;
        end else cyc_d = cyc_q + CW'(1);
      end
      S_WR_HOLD: begin
        if (cyc_q == CW'(HOLD_CYC - 1)) begin
          cyc_d = '0;
          if (fill_q + 32'd1 < num_q) begin
            fill_d  = fill_q + 32'd1;
            state_d = S_FILL_NEXT;
          end else state_d = S_IDLE;
        end else cyc_d = cyc_q + CW'(1);
      end
      S_FILL_NEXT: state_d = S_WR_SETUP;
      S_RD_SETUP: begin
        if (cyc_q == CW'(SETUP_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_RD_PULSE;
        end else cyc_d = cyc_q + CW'(1);
      end
      S_RD_PULSE: begin
        if (cyc_q == CW'(PULSE_CYC - 1)) begin
          cyc_d   = '0;
          rdata_d = sram_data_read;
          state_d = S_IDLE;
        end else cyc_d = cyc_q + CW'(1);
      end
      S_TX_RDY: if (tx_ready) state_d = S_TX_ACK;
      S_TX_ACK: if (!tx_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state and registered, so every
  // SRAM strobe is glitch-free and aligned with the state register.
  always_comb begin
    wr_phase    = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                  (state_d == S_WR_HOLD);
    rd_phase    = (state_d == S_RD_SETUP) || (state_d == S_RD_PULSE);
    ce_n_d      = !(wr_phase || rd_phase);
    we_n_d      = (state_d != S_WR_PULSE);
    oe_n_d      = (state_d != S_RD_PULSE);
    data_oe_d   = wr_phase;
    busy_d      = (state_d != S_IDLE);
    tx_strb_d   = (state_d == S_TX_ACK);
    sram_addr_d = sram_addr_q;
    wr_data_d   = wr_data_q;
    if (wr_phase) begin
      sram_addr_d = addr_reg_q + ADDR_W'(fill_d);
      wr_data_d   = count_d ? (wdata_q + fill_d[7:0]) : wdata_q;
    end else if (rd_phase) begin
      sram_addr_d = addr_reg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      fill_q      <= '0;
      num_q       <= '0;
      count_q     <= 1'b0;
      frame_q     <= '0;
      addr_reg_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
      tx_strb_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      fill_q      <= fill_d;
      num_q       <= num_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      addr_reg_q  <= addr_reg_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      data_oe_q   <= data_oe_d;
      tx_strb_q   <= tx_strb_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign sram_addr       = sram_addr_q;
  assign sram_data_write = wr_data_q;
  assign sram_data_oe    = data_oe_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_oe_n       = oe_n_q;
  assign tx_data         = tx_data_q;
  assign tx_strb         = tx_strb_q;
  assign busy            = busy_q;
  assign err             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_cmd_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_sram_cmd_sequencer : directed frame vectors with an SRAM bus       |
// | monitor and hand-written read-back, reset and timeout sequences.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sram_cmd_sequencer;
  import sram_cmd_sequencer_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_strb = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_strb;
  logic [15:0] sram_addr;
  logic [7:0]  sram_data_write, sram_data_read;
  logic        sram_data_oe, sram_ce_n, sram_we_n, sram_oe_n, busy, err;

  always #5 clk = ~clk;

  sram_cmd_sequencer #(
    .ADDR_W(16), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strb(rx_strb),
    .tx_data(tx_data), .tx_strb(tx_strb), .tx_ready(tx_ready),
    .sram_addr(sram_addr), .sram_data_write(sram_data_write),
    .sram_data_oe(sram_data_oe), .sram_data_read(sram_data_read),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int setup, pulse, hold, doe, unst;
  } wrec_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  term;
    int          exp_wr, exp_err, exp_ce;
    logic [15:0] fa;
    logic [7:0]  fd;
    logic [15:0] la;
    logic [7:0]  ld;
  } vec_t;

  int n_checks = 0, n_errors = 0;

  // SRAM model and bus monitor
  logic [7:0] mem [0:65535];
  wrec_t wr_q[$];
  wrec_t cur;
  bit    in_win = 0, cur_wr = 0;
  int    cur_rdp = 0, rd_setup = 0, rd_pulse = 0;
  int    err_cnt = 0, ce_cycles = 0, viol = 0;

  assign sram_data_read = (!sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (!sram_we_n && !sram_oe_n) viol++;
    if (!sram_oe_n && sram_data_oe) viol++;
    if (!sram_we_n && sram_ce_n) viol++;
    if (!sram_ce_n) begin
      ce_cycles++;
      if (!in_win) begin
        in_win = 1;
        cur = '{sram_addr, sram_data_write, 0, 0, 0, 0, 0};
        cur_wr = 0;
        cur_rdp = 0;
      end
      if (sram_data_oe) cur.doe = cur.doe + 1;
      if (sram_addr != cur.addr || (sram_data_oe && sram_data_write != cur.data))
        cur.unst = cur.unst + 1;
      if (!sram_we_n) begin
        cur.pulse = cur.pulse + 1;
        cur_wr = 1;
        mem[sram_addr] = sram_data_write;
      end else if (!sram_oe_n) cur_rdp++;
      else if (cur_wr) cur.hold = cur.hold + 1;
      else cur.setup = cur.setup + 1;
    end else if (in_win) begin
      in_win = 0;
      if (cur_wr) wr_q.push_back(cur);
      else if (cur_rdp > 0) begin
        rd_setup = cur.setup;
        rd_pulse = cur_rdp;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_strb = 1'b1;
    @(posedge clk); #1;
    rx_strb = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [7:0] t);
    send_byte(c);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(t);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id, output int base);
    int eb, cb, nw, bad;
    string nm;
    nm = $sformatf("v%0d", id);
    base = wr_q.size();
    eb = err_cnt;
    cb = ce_cycles;
    send_frame(v.cmd, v.arg, v.term);
    wait_idle(nm);
    nw = wr_q.size() - base;
    check({nm, "_writes"}, nw, v.exp_wr);
    check({nm, "_errs"}, err_cnt - eb, v.exp_err);
    check({nm, "_ce_cycles"}, ce_cycles - cb, v.exp_ce);
    if (v.exp_wr > 0 && nw > 0) begin
      check({nm, "_first_addr"}, wr_q[base].addr, v.fa);
      check({nm, "_first_data"}, wr_q[base].data, v.fd);
      check({nm, "_last_addr"}, wr_q[base+nw-1].addr, v.la);
      check({nm, "_last_data"}, wr_q[base+nw-1].data, v.ld);
      bad = 0;
      for (int k = base; k < base + nw; k++)
        if (wr_q[k].setup != 2 || wr_q[k].pulse != 3 || wr_q[k].hold != 1 ||
            wr_q[k].doe != 6 || wr_q[k].unst != 0) bad++;
      check({nm, "_timing_bad"}, bad, 0);
    end
  endtask

  vec_t vecs[17];
  vec_t tv;
  int   base, cnt_base, n;

  initial begin
    vecs[0]  = '{CMD_ADDR,     32'h1234, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[1]  = '{CMD_LOAD,     32'h00A5, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[2]  = '{CMD_WRITE,    32'hDEAD, 8'h00, 1, 0, 6, 16'h1234, 8'hA5, 16'h1234, 8'hA5};
    vecs[3]  = '{CMD_ADDR,     32'hFFFE, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[4]  = '{CMD_LOAD,     32'h00FE, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[5]  = '{CMD_COUNT,    32'd4,    8'h00, 4, 0, 24, 16'hFFFE, 8'hFE, 16'h0001, 8'h01};
    vecs[6]  = '{CMD_WRITE,    32'h0,    8'h00, 1, 0, 6, 16'hFFFE, 8'hFE, 16'hFFFE, 8'hFE};
    vecs[7]  = '{CMD_COUNT,    32'd0,    8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[8]  = '{CMD_ADDR,     32'h0777, 8'h55, 0, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[9]  = '{CMD_ADDR,     32'h0010, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[10] = '{CMD_WRITE,    32'h0,    8'h00, 1, 0, 6, 16'h0010, 8'hFE, 16'h0010, 8'hFE};
    vecs[11] = '{8'h09,        32'h0,    8'h00, 0, 1, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[12] = '{CMD_CONST,    32'd3,    8'h00, 3, 0, 18, 16'h0010, 8'hFE, 16'h0012, 8'hFE};
    vecs[13] = '{CMD_ADDR,     32'h0001, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[14] = '{CMD_LOAD,     32'h003C, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    vecs[15] = '{CMD_WRITE,    32'h0,    8'h00, 1, 0, 6, 16'h0001, 8'h3C, 16'h0001, 8'h3C};
    vecs[16] = '{CMD_READ_REQ, 32'h0,    8'h00, 0, 0, 5, 16'h0, 8'h0, 16'h0, 8'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_data_oe", sram_data_oe, 0);
    check("rst_tx_strb", tx_strb, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_data_write, 0);
    check("rst_tx_data", tx_data, 0);

    cnt_base = 0;
    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], i, base);
      if (i == 5) cnt_base = base;
    end
    check("count_w1_addr", wr_q[cnt_base+1].addr, 16'hFFFF);
    check("count_w1_data", wr_q[cnt_base+1].data, 8'hFF);
    check("count_w2_addr", wr_q[cnt_base+2].addr, 16'h0000);
    check("count_w2_data", wr_q[cnt_base+2].data, 8'h00);
    check("rd_setup", rd_setup, 2);
    check("rd_pulse", rd_pulse, 3);

    // READ: tx_strb must wait for tx_ready and fall only after tx_ready drops
    tx_ready = 1'b0;
    send_frame(CMD_READ, 32'h0, 8'h00);
    repeat (4) @(negedge clk);
    check("tx_wait_strb", tx_strb, 0);
    check("tx_wait_busy", busy, 1);
    @(posedge clk); #1 tx_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_strb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_strb_rise", tx_strb, 1);
    check("tx_data", tx_data, 8'h3C);
    repeat (3) @(negedge clk);
    check("tx_strb_held", tx_strb, 1);
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    check("tx_strb_before_ack", tx_strb, 1);
    @(negedge clk);
    check("tx_strb_fall", tx_strb, 0);
    check("tx_busy_end", busy, 0);
    tx_ready = 1'b1;

    // Reset asserted in the first WR_PULSE cycle of CONST 100
    tv = '{CMD_ADDR, 32'h0100, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    run_vec(tv, 20, base);
    tv = '{CMD_LOAD, 32'h0033, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    run_vec(tv, 21, base);
    send_frame(CMD_CONST, 32'd100, 8'h00);
    n = 0;
    @(negedge clk);
    while (sram_we_n && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_found_pulse", sram_we_n, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we_n", sram_we_n, 1);
    check("rst_mid_ce_n", sram_ce_n, 1);
    check("rst_mid_data_oe", sram_data_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", sram_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) run_vec(vecs[i], 30 + i, base);

    // Partial frame abandoned by the rx timeout, then a clean LOAD + WRITE
    send_byte(CMD_CONST);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (TMO + 20) @(posedge clk);
    tv = '{CMD_LOAD, 32'h005A, 8'h00, 0, 0, 0, 16'h0, 8'h0, 16'h0, 8'h0};
    run_vec(tv, 40, base);
    tv = '{CMD_WRITE, 32'h0, 8'h00, 1, 0, 6, 16'h1234, 8'h5A, 16'h1234, 8'h5A};
    run_vec(tv, 41, base);

    check("bus_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
